// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller for a 5-stage RV32I pipeline: D-stage stall and ALU operand selects.
// Define HAZ_MDU_EN to add the multi-cycle MDU interlock (R-type with funct7=0000001).
module hazard_fwd_unit #(
    parameter int unsigned NUM_FWD  = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MDU_LAT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instD,
    input  logic        validD,
    input  logic        flush,
    input  logic        alumux1,
    input  logic        alumux2,
    output logic        stall,
    output logic [2:0]  ASrc,
    output logic [2:0]  BSrc,
    output logic        mdu_busy
);

    localparam logic [4:0] OpLoad   = 5'b00000;
    localparam logic [4:0] OpImm    = 5'b00100;
    localparam logic [4:0] OpAuipc  = 5'b00101;
    localparam logic [4:0] OpStore  = 5'b01000;
    localparam logic [4:0] OpReg    = 5'b01100;
    localparam logic [4:0] OpLui    = 5'b01101;
    localparam logic [4:0] OpBranch = 5'b11000;
    localparam logic [4:0] OpJalr   = 5'b11001;
    localparam logic [4:0] OpJal    = 5'b11011;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
        logic       mdu;
    } shadow_t;

    typedef struct packed {
        logic       blk;
        logic [2:0] src;
    } opsel_t;

    if (NUM_FWD < 1 || NUM_FWD > 3 || LOAD_LAT < 1 || LOAD_LAT > 2 || MDU_LAT < 2)
    begin : g_param_check
        $error("hazard_fwd_unit: unsupported parameter set");
    end

    logic [4:0]    opc;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          use_rs1;
    logic          use_rs2;
    logic          wr_rd;
    logic          is_load;
    logic          is_mdu;
    shadow_t       dec_ent;
    shadow_t [2:0] sh_q;
    shadow_t [2:0] sh_d;
    logic          mdu_stall;
    logic          mdu_ready;
    opsel_t        sel_a;
    opsel_t        sel_b;

    assign opc = instD[6:2];
    assign rs1 = instD[19:15];
    assign rs2 = instD[24:20];

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_rd   = 1'b0;
        case (opc)
            OpReg: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                wr_rd   = 1'b1;
            end
            OpBranch, OpStore: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OpImm, OpLoad, OpJalr: begin
                use_rs1 = 1'b1;
                wr_rd   = 1'b1;
            end
            OpLui, OpAuipc, OpJal: wr_rd = 1'b1;
            default: ;
        endcase
    end

    assign is_load = (opc == OpLoad) && (instD[14:12] == 3'b010);

`ifdef HAZ_MDU_EN
    logic unused_inst;
    assign unused_inst = ^instD[1:0];
    assign is_mdu      = (opc == OpReg) && (instD[31:25] == 7'b0000001);
`else
    logic unused_inst;
    assign unused_inst = ^{instD[31:25], instD[1:0]};
    assign is_mdu      = 1'b0;
`endif

    assign dec_ent = '{v: validD & wr_rd, rd: instD[11:7], ld: is_load, mdu: is_mdu};

    // Index 0 = E, 1 = M, 2 = W; only the youngest matching writer is considered,
    // since any older match holds a stale value.
    function automatic opsel_t resolve(input logic [4:0] rs, input logic used, input logic am,
                                       input shadow_t [2:0] sh, input logic mdu_rdy);
        opsel_t r;
        logic   hit;
        r   = '{blk: 1'b0, src: {2'b00, am}};
        hit = 1'b0;
        for (int unsigned s = 0; s < 3; s++) begin
            if (!hit && used && rs != 5'd0 && sh[s].v && sh[s].rd == rs) begin
                hit = 1'b1;
                if (s >= NUM_FWD || (sh[s].ld && s < LOAD_LAT) ||
                    (s == 0 && sh[s].mdu && !mdu_rdy)) begin
                    r.blk = 1'b1;
                end else if (!am) begin
                    r.src = 3'(s + 2);
                end
            end
        end
        return r;
    endfunction

    assign sel_a = resolve(rs1, use_rs1, alumux1, sh_q, mdu_ready);
    assign sel_b = resolve(rs2, use_rs2, alumux2, sh_q, mdu_ready);

    assign stall    = sel_a.blk | sel_b.blk | mdu_stall;
    assign ASrc     = sel_a.src;
    assign BSrc     = sel_b.src;
    assign mdu_busy = mdu_stall;

    always_comb begin
        sh_d    = sh_q;
        sh_d[2] = sh_q[1];
        sh_d[1] = sh_q[0];
        sh_d[0] = '0;
        if (flush) begin
            sh_d[0] = '0;
        end else if (mdu_stall) begin
            // MDU op stays in E; a bubble drains into M behind it.
            sh_d[0] = sh_q[0];
            sh_d[1] = '0;
        end else if (!stall) begin
            sh_d[0] = dec_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

`ifdef HAZ_MDU_EN
    localparam int unsigned CntW = $clog2(MDU_LAT);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end else if (!stall && validD && is_mdu) begin
            cnt_d = CntW'(MDU_LAT - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mdu_stall = (cnt_q != '0);
    assign mdu_ready = (cnt_q == '0);
`else
    assign mdu_stall = 1'b0;
    assign mdu_ready = 1'b1;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed vector table, hand sequences and random vs. reference model.
// Two instances: (NUM_FWD=3, LOAD_LAT=1, MDU_LAT=4) and (NUM_FWD=1, LOAD_LAT=2, MDU_LAT=3).
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instD;
    logic        validD;
    logic        flush;
    logic        alumux1;
    logic        alumux2;
    logic        stall0, stall1, busy0, busy1;
    logic [2:0]  as0, bs0, as1, bs1;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.NUM_FWD(3), .LOAD_LAT(1), .MDU_LAT(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .instD(instD), .validD(validD), .flush(flush),
        .alumux1(alumux1), .alumux2(alumux2), .stall(stall0), .ASrc(as0), .BSrc(bs0),
        .mdu_busy(busy0)
    );

    hazard_fwd_unit #(.NUM_FWD(1), .LOAD_LAT(2), .MDU_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .instD(instD), .validD(validD), .flush(flush),
        .alumux1(alumux1), .alumux2(alumux2), .stall(stall1), .ASrc(as1), .BSrc(bs1),
        .mdu_busy(busy1)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    typedef struct { bit v; int rd; bit ld; bit mdu; } ent_t;
    typedef struct { bit r1; bit r2; bit w; bit ld; bit mdu; int rs1; int rs2; int rd; } dec_t;

    ent_t       pipe [2][3];
    int         busy [2];
    logic       exp_st [2];
    logic       exp_bz [2];
    logic [2:0] exp_as [2];
    logic [2:0] exp_bs [2];

    function automatic int cfg_nf(input int c); return (c == 0) ? 3 : 1; endfunction
    function automatic int cfg_ll(input int c); return (c == 0) ? 1 : 2; endfunction
    function automatic int cfg_ml(input int c); return (c == 0) ? 4 : 3; endfunction

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        logic [4:0] op;
        op    = ins[6:2];
        d.rs1 = int'(ins[19:15]);
        d.rs2 = int'(ins[24:20]);
        d.rd  = int'(ins[11:7]);
        d.r1  = op inside {5'b01100, 5'b11000, 5'b01000, 5'b00100, 5'b00000, 5'b11001};
        d.r2  = op inside {5'b01100, 5'b11000, 5'b01000};
        d.w   = op inside {5'b01100, 5'b00100, 5'b00000, 5'b01101, 5'b00101, 5'b11011, 5'b11001};
        d.ld  = (op == 5'b00000) && (ins[14:12] == 3'b010);
`ifdef HAZ_MDU_EN
        d.mdu = (op == 5'b01100) && (ins[31:25] == 7'b0000001);
`else
        d.mdu = 1'b0;
`endif
        return d;
    endfunction

    task automatic model_eval(input int c);
        dec_t d;
        bit   blk;
        d   = decode(instD);
        blk = 0;
        for (int op = 0; op < 2; op++) begin
            int         rs;
            bit         used;
            bit         am;
            bit         found;
            logic [2:0] sel;
            rs    = (op == 0) ? d.rs1 : d.rs2;
            used  = (op == 0) ? d.r1 : d.r2;
            am    = (op == 0) ? alumux1 : alumux2;
            sel   = {2'b00, am};
            found = 0;
            for (int s = 0; s < 3; s++) begin
                if (!found && used && rs != 0 && pipe[c][s].v && pipe[c][s].rd == rs) begin
                    found = 1;
                    // a load's data exists only once it is LOAD_LAT stages past E
                    if (s < cfg_nf(c) && !(pipe[c][s].ld && s < cfg_ll(c)) &&
                        !(s == 0 && pipe[c][s].mdu && busy[c] != 0)) begin
                        if (!am) sel = 3'(s + 2);
                    end else begin
                        blk = 1;
                    end
                end
            end
            if (op == 0) exp_as[c] = sel;
            else         exp_bs[c] = sel;
        end
        exp_st[c] = blk || (busy[c] != 0);
        exp_bz[c] = (busy[c] != 0);
    endtask

    task automatic model_step(input int c);
        dec_t d;
        ent_t bub;
        d   = decode(instD);
        bub = '{v: 0, rd: 0, ld: 0, mdu: 0};
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) pipe[c][s] = bub;
            busy[c] = 0;
        end else if (flush) begin
            pipe[c][2] = pipe[c][1];
            pipe[c][1] = pipe[c][0];
            pipe[c][0] = bub;
            busy[c]    = 0;
        end else if (busy[c] != 0) begin
            pipe[c][2] = pipe[c][1];
            pipe[c][1] = bub;
            busy[c]    = busy[c] - 1;
        end else begin
            pipe[c][2] = pipe[c][1];
            pipe[c][1] = pipe[c][0];
            if (exp_st[c] || !validD) begin
                pipe[c][0] = bub;
            end else begin
                pipe[c][0] = '{v: d.w, rd: d.rd, ld: d.ld, mdu: d.mdu};
                if (d.mdu) busy[c] = cfg_ml(c) - 1;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_model(input int c);
        string p;
        p = (c == 0) ? "d0" : "d1";
        chk({p, ".stall"}, (c == 0) ? 32'(stall0) : 32'(stall1), 32'(exp_st[c]));
        chk({p, ".ASrc"},  (c == 0) ? 32'(as0) : 32'(as1),       32'(exp_as[c]));
        chk({p, ".BSrc"},  (c == 0) ? 32'(bs0) : 32'(bs1),       32'(exp_bs[c]));
        chk({p, ".busy"},  (c == 0) ? 32'(busy0) : 32'(busy1),   32'(exp_bz[c]));
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic fl,
                         input logic a1, input logic a2);
        instD   = ins;
        validD  = v;
        flush   = fl;
        alumux1 = a1;
        alumux2 = a2;
        #2;
        model_eval(0);
        model_eval(1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input int rd, input int a,
                                          input int b);
        return {f7, 5'(b), 5'(a), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] add(input int rd, input int a, input int b);
        return rtype(7'b0000000, rd, a, b);
    endfunction
    function automatic logic [31:0] mul(input int rd, input int a, input int b);
        return rtype(7'b0000001, rd, a, b);
    endfunction
    function automatic logic [31:0] addi(input int rd, input int a, input int imm);
        return {12'(imm), 5'(a), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] lw(input int rd, input int a);
        return {12'd0, 5'(a), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] sw(input int src, input int a, input int imm);
        return {7'd0, 5'(src), 5'(a), 3'b010, 5'(imm), 7'b0100011};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 10);
        w[11:10] = 2'b00;
        w[19:18] = 2'b00;
        w[24:23] = 2'b00;
        case (k)
            0: begin w[6:0] = 7'b0110011; w[31:25] = 7'd0; end
            1: begin w[6:0] = 7'b0110011; w[31:25] = 7'b0000001; end
            2: w[6:0] = 7'b0010011;
            3: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
            4: begin w[6:0] = 7'b0000011; w[14:12] = 3'b000; end
            5: w[6:0] = 7'b0100011;
            6: w[6:0] = 7'b1100011;
            7: w[6:0] = 7'b0110111;
            8: w[6:0] = 7'b1101111;
            9: w[6:0] = 7'b1100111;
            default: ;
        endcase
        return w;
    endfunction

    typedef struct {
        logic [31:0] ins;
        logic        v, fl, a1, a2, st;
        logic [2:0]  as, bs;
    } vec_t;

    vec_t tbl [21];

    initial begin
        // Expected values for instance 0 (NUM_FWD=3, LOAD_LAT=1), one row per cycle.
        tbl[0]  = '{add(5, 1, 2),    1, 0, 0, 0, 0, 3'd0, 3'd0};
        tbl[1]  = '{rtype(7'b0100000, 6, 5, 3), 1, 0, 0, 0, 0, 3'd2, 3'd0};
        tbl[2]  = '{add(7, 3, 5),    1, 0, 0, 0, 0, 3'd0, 3'd3};
        tbl[3]  = '{add(8, 5, 6),    1, 0, 0, 0, 0, 3'd4, 3'd3};
        tbl[4]  = '{lw(9, 1),        1, 0, 0, 1, 0, 3'd0, 3'd1};
        tbl[5]  = '{add(10, 1, 9),   1, 0, 0, 0, 1, 3'd0, 3'd0};
        tbl[6]  = '{add(10, 1, 9),   1, 0, 0, 0, 0, 3'd0, 3'd3};
        tbl[7]  = '{addi(0, 1, 1),   1, 0, 0, 1, 0, 3'd0, 3'd1};
        tbl[8]  = '{add(2, 0, 0),    1, 0, 0, 0, 0, 3'd0, 3'd0};
        tbl[9]  = '{add(11, 10, 2),  1, 0, 1, 0, 0, 3'd1, 3'd2};
        tbl[10] = '{addi(5, 0, 3),   1, 0, 0, 1, 0, 3'd0, 3'd1};
        tbl[11] = '{add(12, 0, 0),   1, 0, 0, 0, 0, 3'd0, 3'd0};
        tbl[12] = '{addi(5, 0, 7),   1, 0, 0, 1, 0, 3'd0, 3'd1};
        tbl[13] = '{add(13, 5, 5),   1, 0, 0, 0, 0, 3'd2, 3'd2};
        tbl[14] = '{add(14, 13, 0),  0, 0, 0, 0, 0, 3'd2, 3'd0};
        tbl[15] = '{lw(15, 13),      1, 1, 0, 1, 0, 3'd3, 3'd1};
        tbl[16] = '{add(16, 15, 15), 1, 0, 0, 0, 0, 3'd0, 3'd0};
        tbl[17] = '{sw(16, 16, 4),   1, 0, 0, 1, 0, 3'd2, 3'd1};
        tbl[18] = '{lw(17, 16),      1, 0, 0, 1, 0, 3'd3, 3'd1};
        tbl[19] = '{lw(18, 17),      1, 0, 0, 1, 1, 3'd0, 3'd1};
        tbl[20] = '{lw(18, 17),      1, 0, 0, 1, 0, 3'd3, 3'd1};

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset values: selects pass the decoder choice through.
        drive(add(3, 4, 4), 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst.stall", 32'(stall0), 0);
        chk("rst.busy",  32'(busy0), 0);
        chk("rst.ASrc",  32'(as0), 1);
        chk("rst.BSrc",  32'(bs0), 0);
        chk("rst.stall1", 32'(stall1), 0);
        do_reset();

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].ins, tbl[i].v, tbl[i].fl, tbl[i].a1, tbl[i].a2);
            chk($sformatf("tbl%0d.stall", i), 32'(stall0), 32'(tbl[i].st));
            chk($sformatf("tbl%0d.ASrc", i),  32'(as0),    32'(tbl[i].as));
            chk($sformatf("tbl%0d.BSrc", i),  32'(bs0),    32'(tbl[i].bs));
            chk($sformatf("tbl%0d.busy", i),  32'(busy0),  0);
            check_model(1);
            tick();
        end

        // NUM_FWD=1: a writer in M or W cannot be forwarded, so D waits until it retires.
        do_reset();
        drive(add(5, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0); check_model(0); tick();
        drive(add(3, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0); check_model(0); tick();
        drive(add(6, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("nf1.m.stall", 32'(stall1), 1);
        chk("nf1.m.d0",    32'(as0), 3);
        tick();
        drive(add(6, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("nf1.w.stall", 32'(stall1), 1);
        check_model(0);
        tick();
        drive(add(6, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("nf1.ret.stall", 32'(stall1), 0);
        chk("nf1.ret.ASrc",  32'(as1), 0);
        tick();

        // Reset in the middle of a load-use stall clears the shadow pipeline.
        do_reset();
        drive(lw(5, 1), 1'b1, 1'b0, 1'b0, 1'b1); tick();
        drive(add(6, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rstld.pre", 32'(stall0), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(add(6, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rstld.stall", 32'(stall0), 0);
        chk("rstld.ASrc",  32'(as0), 0);

`ifdef HAZ_MDU_EN
        do_reset();
        drive(mul(7, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mdu.enter.stall", 32'(stall0), 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(add(8, 7, 0), 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("mdu.busy%0d", k),  32'(busy0), 1);
            chk($sformatf("mdu.stall%0d", k), 32'(stall0), 1);
            check_model(1);
            tick();
        end
        drive(add(8, 7, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mdu.done.busy",  32'(busy0), 0);
        chk("mdu.done.stall", 32'(stall0), 0);
        chk("mdu.done.ASrc",  32'(as0), 2);
        tick();

        // Flush during an MDU stall cancels the countdown.
        do_reset();
        drive(mul(9, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(add(10, 9, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mduf.busy", 32'(busy0), 1);
        tick();
        drive(32'h0000_0013, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        drive(add(10, 9, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mduf.after.busy",  32'(busy0), 0);
        chk("mduf.after.stall", 32'(stall0), 0);
        chk("mduf.after.ASrc",  32'(as0), 3);
        tick();

        do_reset();
        drive(mul(11, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(add(12, 11, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mdur.pre", 32'(stall0), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(add(12, 11, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mdur.stall", 32'(stall0), 0);
        chk("mdur.busy",  32'(busy0), 0);
        chk("mdur.ASrc",  32'(as0), 0);
`else
        // Without the MDU interlock, mul is an ordinary single-cycle R-type writer.
        do_reset();
        drive(mul(7, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(add(8, 7, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mul.stall", 32'(stall0), 0);
        chk("mul.busy",  32'(busy0), 0);
        chk("mul.ASrc",  32'(as0), 2);
`endif
        tick();

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            drive(rand_ins(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_model(0);
            check_model(1);
            tick();
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
